// File: rtl/qpu_exu_wbck_queue.sv
// Write-back queue: per-channel result FIFOs plus an in-order commit slot.
// Define QPU_WBCK_BYPASS_EN to let a result reach an empty, ready channel in the accept cycle.
module qpu_exu_wbck_queue #(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int IDXW  = 6,
    parameter int DEPTH = 2,
    parameter int PCW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [NCH-1:0]      i_chsel,
    input  logic [DW-1:0]       i_data,
    input  logic [IDXW-1:0]     i_rdidx,
    input  logic [PCW-1:0]      i_pc,
    output logic                cmt_o_valid,
    input  logic                cmt_o_ready,
    output logic [PCW-1:0]      cmt_o_pc,
    output logic [NCH-1:0]      o_valid,
    input  logic [NCH-1:0]      o_ready,
    output logic [NCH*DW-1:0]   o_data,
    output logic [NCH*IDXW-1:0] o_rdidx,
    output logic                o_idle,
    output logic                o_err
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr   [NCH];
    logic [AW:0]      rd_ptr   [NCH];
    logic [DW-1:0]    mem_data [NCH][DEPTH];
    logic [IDXW-1:0]  mem_idx  [NCH][DEPTH];

    logic             vld;
    logic [PCW-1:0]   pc_q;
    logic             err;

    logic [NCH-1:0]   empty, full, ch_free, push, pop, byp;
    logic             slot_free, sel_legal, sel_free, accept;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
            full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                       (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
        end
    end

    assign ch_free   = ~full | o_ready;
    assign slot_free = ~vld | cmt_o_ready;
    assign sel_legal = ((i_chsel & (i_chsel - NCH'(1))) == '0);
    assign sel_free  = (i_chsel == '0) | (|(i_chsel & ch_free));
    // Gated by rst so no handshake can complete while reset is asserted.
    assign i_ready   = ~rst & slot_free & sel_legal & sel_free;
    assign accept    = i_valid & i_ready;

`ifdef QPU_WBCK_BYPASS_EN
    assign byp = {NCH{accept}} & i_chsel & empty & o_ready;
`else
    assign byp = '0;
`endif

    assign push    = {NCH{accept}} & i_chsel & ~byp;
    assign pop     = ~empty & o_ready & {NCH{~rst}};
    assign o_valid = (~empty | byp) & {NCH{~rst}};

    always_comb begin
        o_data  = '0;
        o_rdidx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (o_valid[k]) begin
                o_data[k*DW +: DW]     = byp[k] ? i_data  : mem_data[k][rd_ptr[k][AW-1:0]];
                o_rdidx[k*IDXW +: IDXW] = byp[k] ? i_rdidx : mem_idx[k][rd_ptr[k][AW-1:0]];
            end
        end
    end

    assign cmt_o_valid = vld & ~rst;
    assign cmt_o_pc    = cmt_o_valid ? pc_q : '0;
    assign o_idle      = (&empty) & ~vld;
    assign o_err       = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
            vld  <= 1'b0;
            pc_q <= '0;
            err  <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + (AW+1)'(1);
            end
            // A load in the same cycle as a drain keeps the slot occupied.
            if (accept) begin
                vld  <= 1'b1;
                pc_q <= i_pc;
            end else if (vld && cmt_o_ready) begin
                vld <= 1'b0;
            end
            if (i_valid && !sel_legal) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (push[k]) begin
                mem_data[k][wr_ptr[k][AW-1:0]] <= i_data;
                mem_idx[k][wr_ptr[k][AW-1:0]]  <= i_rdidx;
            end
        end
    end

endmodule

// File: tb/tb_qpu_exu_wbck_queue.sv
// Directed bench for qpu_exu_wbck_queue in the default build (NCH=4, DEPTH=2, no bypass).
module tb_qpu_exu_wbck_queue;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [3:0]   i_chsel;
    logic [31:0]  i_data;
    logic [5:0]   i_rdidx;
    logic [31:0]  i_pc;
    logic         cmt_o_valid;
    logic         cmt_o_ready;
    logic [31:0]  cmt_o_pc;
    logic [3:0]   o_valid;
    logic [3:0]   o_ready;
    logic [127:0] o_data;
    logic [23:0]  o_rdidx;
    logic         o_idle;
    logic         o_err;

    int n_pass = 0;
    int n_chk  = 0;

    qpu_exu_wbck_queue dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_chsel(i_chsel),
        .i_data(i_data), .i_rdidx(i_rdidx), .i_pc(i_pc),
        .cmt_o_valid(cmt_o_valid), .cmt_o_ready(cmt_o_ready), .cmt_o_pc(cmt_o_pc),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_rdidx(o_rdidx),
        .o_idle(o_idle), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [31:0] d,
                         input logic [5:0] idx, input logic [31:0] pc);
        i_valid = v; i_chsel = sel; i_data = d; i_rdidx = idx; i_pc = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; o_ready = 4'hF; cmt_o_ready = 1'b1;
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // reset state
        chk("rst_idle", o_idle, 1);
        chk("rst_ovalid", o_valid, 0);
        chk("rst_cvalid", cmt_o_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_iready", i_ready, 1);

        // single push to channel 1
        drive(1, 4'b0010, 32'h1234, 6'd5, 32'h40);
        chk("push_iready", i_ready, 1);
        chk("push_noearly", o_valid, 0);
        step();
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        chk("push_ovalid", o_valid, 4'b0010);
        chk("push_data", o_data, {32'h0, 32'h0, 32'h1234, 32'h0});
        chk("push_idx", o_rdidx, {6'd0, 6'd0, 6'd5, 6'd0});
        chk("push_cvalid", cmt_o_valid, 1);
        chk("push_cpc", cmt_o_pc, 32'h40);
        chk("push_busy", o_idle, 0);
        step();
        chk("push_drained", o_idle, 1);

        // back-pressure on channel 0
        o_ready = 4'b1110;
        drive(1, 4'b0001, 32'hA0, 6'd1, 32'h100);
        chk("bp_a_rdy", i_ready, 1);
        step();
        drive(1, 4'b0001, 32'hB0, 6'd2, 32'h104);
        chk("bp_b_rdy", i_ready, 1);
        step();
        drive(1, 4'b0001, 32'hC0, 6'd3, 32'h108);
        chk("bp_full_rdy", i_ready, 0);
        chk("bp_head_a", o_data[31:0], 32'hA0);
        step();
        chk("bp_hold_rdy", i_ready, 0);
        chk("bp_hold_head", o_data[31:0], 32'hA0);
        o_ready = 4'hF;
        #1;
        chk("bp_pushpop_rdy", i_ready, 1);
        step();
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        chk("bp_head_b", o_data[31:0], 32'hB0);
        chk("bp_idx_b", o_rdidx[5:0], 6'd2);
        step();
        chk("bp_head_c", o_data[31:0], 32'hC0);
        step();
        chk("bp_empty", o_valid, 0);
        drive(1, 4'b0001, 32'hD0, 6'd4, 32'h10C);
        step();
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        chk("bp_wrap_d", o_data[31:0], 32'hD0);
        chk("bp_wrap_v", o_valid, 4'b0001);
        step();

        // commit stall
        cmt_o_ready = 1'b0;
        drive(1, 4'h0, 32'h0, 6'h0, 32'h40);
        chk("cs_first_rdy", i_ready, 1);
        step();
        drive(1, 4'h0, 32'h0, 6'h0, 32'h44);
        chk("cs_stall_conly", i_ready, 0);
        drive(1, 4'b0100, 32'h55, 6'h1, 32'h44);
        chk("cs_stall_ch", i_ready, 0);
        chk("cs_pc40", cmt_o_pc, 32'h40);
        step();
        chk("cs_still40", cmt_o_pc, 32'h40);
        chk("cs_no_push", o_valid, 0);
        cmt_o_ready = 1'b1;
        drive(1, 4'h0, 32'h0, 6'h0, 32'h44);
        chk("cs_rel_rdy", i_ready, 1);
        step();
        chk("cs_pc44", cmt_o_pc, 32'h44);
        drive(1, 4'h0, 32'h0, 6'h0, 32'h48);
        step();
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        chk("cs_pc48", cmt_o_pc, 32'h48);
        chk("cs_v48", cmt_o_valid, 1);
        step();
        chk("cs_done", cmt_o_valid, 0);
        chk("cs_pc_zero", cmt_o_pc, 0);

        // illegal select
        drive(1, 4'b0110, 32'h77, 6'h7, 32'h200);
        chk("ill_rdy", i_ready, 0);
        step();
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        chk("ill_err", o_err, 1);
        chk("ill_idle", o_idle, 1);
        step();
        chk("ill_err_hold", o_err, 1);

        // mid-operation reset
        o_ready = 4'h0;
        drive(1, 4'b0001, 32'h11, 6'h1, 32'h300);
        step();
        drive(1, 4'b0100, 32'h33, 6'h3, 32'h304);
        step();
        drive(0, 4'h0, 32'h0, 6'h0, 32'h0);
        chk("mr_hold", o_valid, 4'b0101);
        rst = 1'b1;
        #1;
        chk("mr_rst_rdy", i_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("mr_ovalid", o_valid, 0);
        chk("mr_idle", o_idle, 1);
        chk("mr_err", o_err, 0);
        chk("mr_cvalid", cmt_o_valid, 0);
        o_ready = 4'hF;
        step();
        chk("mr_stale_v", o_valid, 0);
        chk("mr_stale_d", o_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
